// File: rtl/io_frame_bridge.sv
// TDM serial frame bridge between a core's word buses and a serial link.
// Ports: clk, reset_n, bitEn, fsync, sdin, sdout, outputs, inputs, frameDone, syncErr, clrErr.
module io_frame_bridge #(
  parameter int DWW = 36,
  parameter int NCH = 8,
  parameter int SW  = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               bitEn,
  input  logic               fsync,
  input  logic               sdin,
  output logic               sdout,
  input  logic [DWW*NCH-1:0] outputs,
  output logic [DWW*NCH-1:0] inputs,
  output logic               frameDone,
  output logic               syncErr,
  input  logic               clrErr
);

  localparam int FL = NCH * 32;
  localparam int PW = $clog2(FL);
  localparam int CW = PW - 5;
  localparam int GW = DWW - SW - 8;
  localparam int TW = GW + 1;
  localparam logic [PW-1:0] LAST = PW'(FL - 1);
  localparam logic [4:0] SLAST = 5'(SW - 1);

  typedef enum logic {HUNT, RUN} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] pos, pos_nx, pos_inc;
  logic          act, err;

  logic [SW-1:0] shreg;
  logic [SW-1:0] shadow [NCH];
  logic [SW-1:0] txbuf  [NCH];
  logic [SW-1:0] cur;
  logic [CW-1:0] slot;
  logic [4:0]    bp;
  logic          tx_bit;

  // Saturate a word to a sample when it does not fit in SW bits.
  function automatic logic [SW-1:0] tx_conv(input logic [DWW-1:0] w);
    logic [TW-1:0] top;
    top = w[DWW-1:SW+7];
    if (&top || ~|top) return w[SW+7:8];
    return w[DWW-1] ? {1'b1, {(SW-1){1'b0}}}
                    : {1'b0, {(SW-1){1'b1}}};
  endfunction

  function automatic logic [DWW-1:0] rx_conv(input logic [SW-1:0] s);
    return {{GW{s[SW-1]}}, s, 8'h00};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= HUNT;
      pos   <= '0;
    end else begin
      state <= state_nx;
      pos   <= pos_nx;
    end
  end

  // pos holds the last processed position; act marks a bit that is
  // processed at pos_nx, err marks a framing violation.
  always_comb begin
    state_nx = state;
    pos_nx   = pos;
    act      = 1'b0;
    err      = 1'b0;
    pos_inc  = (pos == LAST) ? '0 : pos + 1'b1;
    if (bitEn) begin
      unique case (state)
        HUNT: begin
          if (fsync) begin
            state_nx = RUN;
            pos_nx   = '0;
            act      = 1'b1;
          end
        end
        RUN: begin
          if (fsync) begin
            pos_nx = '0;
            act    = 1'b1;
            err    = (pos_inc != '0);
          end else if (pos_inc == '0) begin
            state_nx = HUNT;
            pos_nx   = '0;
            err      = 1'b1;
          end else begin
            pos_nx = pos_inc;
            act    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Position 0 transmits straight from the bus word being latched.
  always_comb begin
    slot   = pos_nx[PW-1:5];
    bp     = pos_nx[4:0];
    cur    = (pos_nx == '0) ? tx_conv(outputs[DWW-1:0])
                            : txbuf[slot];
    tx_bit = (bp <= SLAST) ? cur[SLAST - bp] : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdout     <= 1'b0;
      frameDone <= 1'b0;
      syncErr   <= 1'b0;
      inputs    <= '0;
      shreg     <= '0;
      for (int k = 0; k < NCH; k++) begin
        shadow[k] <= '0;
        txbuf[k]  <= '0;
      end
    end else begin
      frameDone <= 1'b0;
      if (err) syncErr <= 1'b1;
      else if (clrErr) syncErr <= 1'b0;
      if (bitEn) begin
        if (act) begin
          sdout <= tx_bit;
          shreg <= {shreg[SW-2:0], sdin};
          if (bp == SLAST)
            shadow[slot] <= {shreg[SW-2:0], sdin};
          if (pos_nx == '0)
            for (int k = 0; k < NCH; k++)
              txbuf[k] <= tx_conv(outputs[k*DWW +: DWW]);
          if (pos_nx == LAST) begin
            for (int k = 0; k < NCH; k++)
              inputs[k*DWW +: DWW] <= rx_conv(shadow[k]);
            frameDone <= 1'b1;
          end
        end else begin
          sdout <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_frame_bridge.sv
// Directed/random bench for io_frame_bridge with a frame-level model.
// Drives serial frames, decodes sdout, checks inputs/frameDone/syncErr.
module tb_io_frame_bridge;

  localparam int DWW = 36;
  localparam int NCH = 8;
  localparam int SW  = 24;
  localparam int FL  = NCH * 32;

  logic clk = 1'b0;
  logic reset_n, bitEn, fsync, sdin, clrErr;
  logic sdout, frameDone, syncErr;
  logic [DWW*NCH-1:0] outw, inw, exp_in;
  logic [DWW*NCH-1:0] oa, ob;
  logic [SW-1:0] rx_s [NCH];
  logic [SW-1:0] txslot [NCH];
  int checks = 0;
  int failures = 0;

  io_frame_bridge #(.DWW(DWW), .NCH(NCH), .SW(SW)) dut (
    .clk(clk), .reset_n(reset_n), .bitEn(bitEn),
    .fsync(fsync), .sdin(sdin), .sdout(sdout),
    .outputs(outw), .inputs(inw), .frameDone(frameDone),
    .syncErr(syncErr), .clrErr(clrErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [DWW*NCH-1:0] obs,
                     input logic [DWW*NCH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Received sample value scaled by 2^8, as a 36-bit two's complement word.
  function automatic logic [DWW-1:0] m_rx(input logic [SW-1:0] s);
    longint v;
    v = longint'($signed(s)) * 256;
    return v[DWW-1:0];
  endfunction

  // Word value / 2^8 clamped to the signed 24-bit range.
  function automatic logic [SW-1:0] m_tx(input logic [DWW-1:0] w);
    longint v;
    v = longint'($signed(w[DWW-1:8]));
    if (v > 8388607) return 24'h7FFFFF;
    if (v < -8388608) return 24'h800000;
    return v[SW-1:0];
  endfunction

  function automatic logic [DWW-1:0] rnd_w();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if (r[40]) r[35:32] = {4{r[31]}};
    return r[DWW-1:0];
  endfunction

  function automatic logic [DWW*NCH-1:0] rnd_bus();
    logic [DWW*NCH-1:0] b;
    for (int k = 0; k < NCH; k++) b[k*DWW +: DWW] = rnd_w();
    return b;
  endfunction

  task automatic rnd_rx();
    for (int k = 0; k < NCH; k++) rx_s[k] = 24'($urandom());
  endtask

  task automatic step_bit(input logic fs, input logic d,
                          input logic clr);
    logic last;
    if ($urandom_range(0, 5) == 0) begin
      last = sdout;
      @(negedge clk);
      bitEn = 1'b0;
      fsync = 1'($urandom_range(0, 1));
      sdin  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("idle_sdout_hold", sdout, last);
      chk("idle_frameDone", frameDone, 1'b0);
    end
    @(negedge clk);
    bitEn  = 1'b1;
    fsync  = fs;
    sdin   = d;
    clrErr = clr;
    @(posedge clk); #1;
    bitEn  = 1'b0;
    fsync  = 1'b0;
    clrErr = 1'b0;
  endtask

  task automatic run_frame(input int nb, input logic fs0,
                           input int chg_at,
                           input logic [DWW*NCH-1:0] chg_val);
    logic [DWW*NCH-1:0] lat;
    logic [FL-1:0] txb;
    logic [31:0] sl;
    logic d, done;
    int k, p;
    lat = outw;
    txb = '0;
    for (int i = 0; i < nb; i++) begin
      if (i == chg_at) outw = chg_val;
      k = i / 32;
      p = i % 32;
      d = (p < SW) ? rx_s[k][SW-1-p] : 1'($urandom_range(0, 1));
      step_bit((i == 0) ? fs0 : 1'b0, d, 1'b0);
      txb[i] = sdout;
      done = (nb == FL) && (i == FL - 1);
      if (done)
        for (int j = 0; j < NCH; j++)
          exp_in[j*DWW +: DWW] = m_rx(rx_s[j]);
      chk("frameDone", frameDone, done);
      chk("inputs", inw, exp_in);
    end
    if (nb == FL) begin
      for (int j = 0; j < NCH; j++) begin
        for (int b = 0; b < 32; b++) sl[31-b] = txb[j*32+b];
        chk("tx_sample", sl[31:8], m_tx(lat[j*DWW +: DWW]));
        chk("tx_guard", sl[7:0], 8'h00);
        txslot[j] = sl[31:8];
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bitEn   = 1'b0;
    fsync   = 1'b0;
    sdin    = 1'b0;
    clrErr  = 1'b0;
    outw    = rnd_bus();
    exp_in  = '0;
    repeat (2) @(negedge clk);
    chk("rst_sdout", sdout, 1'b0);
    chk("rst_frameDone", frameDone, 1'b0);
    chk("rst_syncErr", syncErr, 1'b0);
    chk("rst_inputs", inw, '0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      step_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      chk("hunt_sdout", sdout, 1'b0);
    end

    // Frame 1: fixed samples and fixed bus words.
    for (int k = 0; k < NCH; k++)
      rx_s[k] = 24'(32'h100000 * k + 32'h5A);
    outw = rnd_bus();
    outw[0*DWW +: DWW] = 36'h0_1234_5600;
    outw[1*DWW +: DWW] = 36'hF_FFFF_FF00;
    outw[2*DWW +: DWW] = 36'h8_0000_0000;
    outw[3*DWW +: DWW] = 36'h7_FFFF_FF00;
    run_frame(FL, 1'b1, -1, '0);
    chk("in3_const", inw[3*DWW +: DWW], 36'h0_3000_5A00);
    chk("in7_const", inw[7*DWW +: DWW], 36'h0_7000_5A00);
    chk("slot0_const", txslot[0], 24'h123456);
    chk("slot1_const", txslot[1], 24'hFFFFFF);
    chk("slot2_const", txslot[2], 24'h800000);
    chk("slot3_const", txslot[3], 24'h7FFFFF);

    // Frame 2: same samples, bus changes at position 50.
    oa = rnd_bus();
    ob = rnd_bus();
    outw = oa;
    run_frame(FL, 1'b1, 50, ob);
    chk("f2_in3", inw[3*DWW +: DWW], 36'h0_3000_5A00);

    // Frame 3: transmits the changed bus.
    rnd_rx();
    run_frame(FL, 1'b1, -1, '0);
    chk("f3_syncErr", syncErr, 1'b0);

    // Early fsync at position 100 restarts the frame.
    rnd_rx();
    run_frame(100, 1'b1, -1, '0);
    chk("early_pre_err", syncErr, 1'b0);
    rnd_rx();
    outw = rnd_bus();
    run_frame(FL, 1'b1, -1, '0);
    chk("early_syncErr", syncErr, 1'b1);

    // Reset at position 130 with bitEn active.
    rnd_rx();
    outw = rnd_bus();
    run_frame(130, 1'b1, -1, '0);
    @(negedge clk);
    bitEn   = 1'b1;
    sdin    = 1'b1;
    reset_n = 1'b0;
    #1;
    exp_in = '0;
    chk("mid_rst_sdout", sdout, 1'b0);
    chk("mid_rst_frameDone", frameDone, 1'b0);
    chk("mid_rst_syncErr", syncErr, 1'b0);
    chk("mid_rst_inputs", inw, exp_in);
    repeat (3) @(posedge clk);
    #1;
    chk("in_rst_frameDone", frameDone, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    bitEn   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_bit(1'b0, 1'b1, 1'b0);
      chk("post_rst_sdout", sdout, 1'b0);
      chk("post_rst_frameDone", frameDone, 1'b0);
    end
    rnd_rx();
    run_frame(FL, 1'b1, -1, '0);

    // Missing fsync at the boundary; error beats a same-cycle clear.
    step_bit(1'b0, 1'b1, 1'b1);
    chk("miss_syncErr", syncErr, 1'b1);
    chk("miss_sdout", sdout, 1'b0);
    chk("miss_frameDone", frameDone, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_bit(1'b0, 1'b1, 1'b0);
      chk("miss_hunt_sdout", sdout, 1'b0);
      chk("miss_hunt_inputs", inw, exp_in);
    end
    @(negedge clk);
    clrErr = 1'b1;
    @(posedge clk); #1;
    clrErr = 1'b0;
    chk("clr_syncErr", syncErr, 1'b0);
    rnd_rx();
    outw = rnd_bus();
    run_frame(FL, 1'b1, -1, '0);
    chk("resume_syncErr", syncErr, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
